// File: rtl/uart_boot_loader.sv
// UART boot loader: packs received bytes little-endian into 32-bit words and
// writes them to consecutive ICCM word addresses while holding the core in
// reset. A marker word ends the session. Overflow and a stalled partial word
// both latch an error, and the core is then never released.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for the first byte; core not held
//   LOAD   | packing bytes and writing words; core held in reset
//   DONE   | marker received; image complete, core released (sticky)
//   ERR    | overflow or partial-word timeout; core stays held (sticky)
module uart_boot_loader #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] END_MARKER  = 32'h0000_0FFF,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_dv_i,
    input  logic [7:0]            rx_byte_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           wdata_o,
    output logic                  prog_busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   word_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // Word count at which the ICCM is completely filled.
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           buf_q, buf_d;
    logic [31:0]           tmo_q, tmo_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [31:0]           word;

    // The fourth byte completes the word combinationally so it can be
    // evaluated in the same cycle it arrives.
    assign word = {rx_byte_i, buf_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            buf_q   <= 24'd0;
            tmo_q   <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: byte packing, word evaluation and partial-word timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        tmo_d   = tmo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (rx_dv_i) begin
                    state_d     = S_LOAD;
                    busy_d      = 1'b1;
                    buf_d[7:0]  = rx_byte_i;
                    idx_d       = 2'd1;
                    tmo_d       = 32'd0;
                end
            end
            S_LOAD: begin
                if (rx_dv_i) begin
                    tmo_d = 32'd0;
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: buf_d[7:0]   = rx_byte_i;
                        2'd1: buf_d[15:8]  = rx_byte_i;
                        2'd2: buf_d[23:16] = rx_byte_i;
                        default: begin
                            // Marker wins over the full check so a full
                            // ICCM can still be closed cleanly.
                            if (word == END_MARKER) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end else if (cnt_q == FULL_CNT) begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                            end else begin
                                we_d    = 1'b1;
                                addr_d  = cnt_q[ADDR_WIDTH-1:0];
                                wdata_d = word;
                                cnt_d   = cnt_q + CNT_ONE;
                            end
                        end
                    endcase
                end else if (idx_q != 2'd0) begin
                    // Gaps between whole words are legal; only a stalled
                    // partial word is timed.
                    if (tmo_q == TIMEOUT_CYC - 32'd1) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        tmo_d   = TIMEOUT_CYC;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            default: begin
                // DONE and ERR ignore further bytes and hold all outputs.
            end
        endcase
    end

    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign prog_busy_o = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: a default-parameter instance (A) and a small
// instance (B, 4-word ICCM, 50-cycle timeout) share one byte driver that is
// routed to either by sel.
module tb_uart_boot_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        sel = 1'b0;

    logic        rx_dv_a, rx_dv_b;
    logic        we_a, busy_a, done_a, err_a;
    logic [11:0] addr_a;
    logic [31:0] wdata_a;
    logic [12:0] cnt_a;
    logic        we_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  cnt_b;

    int tests = 0;
    int failures = 0;
    int wr_a = 0;
    int wr_b = 0;

    assign rx_dv_a = rx_dv & ~sel;
    assign rx_dv_b = rx_dv & sel;

    always #5 clock = ~clock;

    uart_boot_loader dut_a (
        .clock(clock), .reset(reset), .rx_dv_i(rx_dv_a), .rx_byte_i(rx_byte),
        .we_o(we_a), .addr_o(addr_a), .wdata_o(wdata_a), .prog_busy_o(busy_a),
        .done_o(done_a), .err_o(err_a), .word_cnt_o(cnt_a)
    );

    uart_boot_loader #(.ADDR_WIDTH(2), .TIMEOUT_CYC(32'd50)) dut_b (
        .clock(clock), .reset(reset), .rx_dv_i(rx_dv_b), .rx_byte_i(rx_byte),
        .we_o(we_b), .addr_o(addr_b), .wdata_o(wdata_b), .prog_busy_o(busy_b),
        .done_o(done_b), .err_o(err_b), .word_cnt_o(cnt_b)
    );

    // Count write strobes, sampled away from the active edge.
    always @(negedge clock) begin
        if (we_a) wr_a++;
        if (we_b) wr_b++;
    end

    typedef struct {
        logic [31:0] word;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_data;
        logic [12:0] exp_cnt;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rx_dv = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clock);
        #1 rx_dv = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            idle(gap);
            send_byte(w[8*k +: 8]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        vecs[0] = '{32'h1122_3344, 1'b1, 12'd0, 32'h1122_3344, 13'd1, 1'b1, 1'b0};
        vecs[1] = '{32'hA5A5_0001, 1'b1, 12'd1, 32'hA5A5_0001, 13'd2, 1'b1, 1'b0};
        vecs[2] = '{32'hDEAD_BEEF, 1'b1, 12'd2, 32'hDEAD_BEEF, 13'd3, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0FFF, 1'b0, 12'd2, 32'hDEAD_BEEF, 13'd3, 1'b0, 1'b1};

        // Reset state and single word followed by the marker.
        sel = 1'b0;
        @(posedge clock);
        #1;
        do_reset();
        check("rst_we", {31'd0, we_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done_err", {30'd0, done_a, err_a}, 32'd0);
        check("rst_cnt", {19'd0, cnt_a}, 32'd0);
        check("rst_addr_wdata", {20'd0, addr_a} | wdata_a, 32'd0);
        base = wr_a;
        send_byte(8'h78);
        check("t1_busy_first", {31'd0, busy_a}, 32'd1);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        check("t1_we", {31'd0, we_a}, 32'd1);
        check("t1_addr", {20'd0, addr_a}, 32'd0);
        check("t1_wdata", wdata_a, 32'h1234_5678);
        check("t1_cnt", {19'd0, cnt_a}, 32'd1);
        send_byte(8'hFF);
        check("t1_we_pulse", {31'd0, we_a}, 32'd0);
        send_byte(8'h0F);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t1_done", {31'd0, done_a}, 32'd1);
        check("t1_busy_rel", {31'd0, busy_a}, 32'd0);
        check("t1_cnt_final", {19'd0, cnt_a}, 32'd1);
        idle(3);
        check("t1_writes", wr_a - base, 32'd1);
        check("t1_hold_wdata", wdata_a, 32'h1234_5678);

        // Three words plus marker, bytes 20 cycles apart.
        do_reset();
        base = wr_a;
        for (int i = 0; i < 4; i++) begin
            send_word(vecs[i].word, 19);
            check($sformatf("t2_we[%0d]", i), {31'd0, we_a}, {31'd0, vecs[i].exp_we});
            check($sformatf("t2_addr[%0d]", i), {20'd0, addr_a}, {20'd0, vecs[i].exp_addr});
            check($sformatf("t2_wdata[%0d]", i), wdata_a, vecs[i].exp_data);
            check($sformatf("t2_cnt[%0d]", i), {19'd0, cnt_a}, {19'd0, vecs[i].exp_cnt});
            check($sformatf("t2_busy[%0d]", i), {31'd0, busy_a}, {31'd0, vecs[i].exp_busy});
            check($sformatf("t2_done[%0d]", i), {31'd0, done_a}, {31'd0, vecs[i].exp_done});
        end
        idle(2);
        check("t2_writes", wr_a - base, 32'd3);

        // Reset mid-word discards the partial word; bytes after DONE ignored.
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        check("t5_busy_after_rst", {31'd0, busy_a}, 32'd0);
        base = wr_a;
        send_word(32'hDDCC_BBAA, 0);
        check("t5_we", {31'd0, we_a}, 32'd1);
        check("t5_addr", {20'd0, addr_a}, 32'd0);
        check("t5_wdata", wdata_a, 32'hDDCC_BBAA);
        send_word(32'h0000_0FFF, 0);
        check("t5_done", {31'd0, done_a}, 32'd1);
        send_word(32'h0403_0201, 0);
        idle(2);
        check("t5_ignored_writes", wr_a - base, 32'd1);
        check("t5_ignored_cnt", {19'd0, cnt_a}, 32'd1);

        // Small ICCM overflow.
        sel = 1'b1;
        do_reset();
        base = wr_b;
        for (int i = 0; i < 4; i++) begin
            send_word(32'h0000_0100 + i, 0);
            check($sformatf("t3_we[%0d]", i), {31'd0, we_b}, 32'd1);
            check($sformatf("t3_addr[%0d]", i), {30'd0, addr_b}, i);
            check($sformatf("t3_wdata[%0d]", i), wdata_b, 32'h0000_0100 + i);
        end
        check("t3_cnt_full", {29'd0, cnt_b}, 32'd4);
        send_word(32'hCAFE_0005, 0);
        check("t3_err", {31'd0, err_b}, 32'd1);
        check("t3_no_we", {31'd0, we_b}, 32'd0);
        check("t3_busy", {31'd0, busy_b}, 32'd1);
        idle(5);
        check("t3_writes", wr_b - base, 32'd4);
        check("t3_busy_hold", {31'd0, busy_b}, 32'd1);

        // Timeout: long gaps between whole words are fine, stalled partial is not.
        do_reset();
        base = wr_b;
        send_word(32'h0102_0304, 0);
        idle(1000);
        send_word(32'h0506_0708, 0);
        check("t4_gap_no_err", {31'd0, err_b}, 32'd0);
        check("t4_gap_cnt", {29'd0, cnt_b}, 32'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(45);
        check("t4_before_tmo", {31'd0, err_b}, 32'd0);
        idle(10);
        check("t4_tmo_err", {31'd0, err_b}, 32'd1);
        check("t4_tmo_busy", {31'd0, busy_b}, 32'd1);
        send_word(32'h0000_0FFF, 0);
        idle(2);
        check("t4_err_ignores", {31'd0, done_b}, 32'd0);
        check("t4_writes", wr_b - base, 32'd2);
        check("t4_cnt_hold", {29'd0, cnt_b}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
